uart_tx_mmio: RTL and testbench
===============================

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 32'h10010024, byte address of the DATA register; STATUS is at BASE_ADDR+4 and DIV at BASE_ADDR+8.
REQ-002 Parameter DIV_RESET, default 16'd434, clocks per UART bit after reset.
REQ-003 Parameter FIFO_DEPTH, default 4, TX FIFO entries; fixed at 4 for this revision.
REQ-004 Port clk, input, 1, the single processor clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port memwrite, input, 1, store strobe from the processor's EX/MEM stage.
REQ-007 Port memread, input, 1, load strobe from the processor's EX/MEM stage.
REQ-008 Port data_address, input, 32, byte address of the current access.
REQ-009 Port writedata, input, 32, store data.
REQ-010 Port received_data, output, 32, load data returned to the processor.
REQ-011 Port tx, output, 1, UART serial line, idle high.
REQ-012 Port irq_empty, output, 1, high while the FIFO is empty and the transmitter is idle.

Function
REQ-013 Address decode SHALL be a full 32-bit equality compare against BASE_ADDR, BASE_ADDR+4 and BASE_ADDR+8; any other address is unmapped.
REQ-014 received_data SHALL be combinational from data_address and memread in the same cycle, with zero latency, because the processor captures it at the next edge.
REQ-015 Reads SHALL return: DATA -> 0; STATUS -> {26'b0, count[2:0], ovf, empty, busy} (bit0 busy, bit1 empty, bit2 ovf, bits5:3 count); DIV -> {16'b0, div}; unmapped address or memread=0 -> 32'h0.
REQ-016 A memwrite to DATA SHALL push writedata[7:0] into the FIFO at that edge if count<4.
REQ-017 A memwrite to DATA while count==4 SHALL drop the byte and set the sticky ovf flag.
REQ-018 A memread of STATUS SHALL clear ovf at that edge; the read still returns the pre-clear value. If a set and a clear occur in the same cycle, the set wins.
REQ-019 A memwrite to DIV SHALL load writedata[15:0] into div. A frame already in progress keeps the divider latched at its start; the new value applies from the next frame.
REQ-020 A latched divider of 0 SHALL be treated as 1.
REQ-021 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-022 IDLE: tx=1; if the FIFO is non-empty, the FSM pops the head into an 8-bit shift register, latches div, clears the bit counters and goes to START.
REQ-023 START: tx=0 for N clocks, then DATA.
REQ-024 DATA: tx=shift[0] for N clocks per bit, LSB first, 8 bits, then STOP.
REQ-025 STOP: tx=1 for N clocks, then IDLE.
REQ-026 A frame is exactly 10*N clocks; back-to-back frames SHALL have exactly one IDLE cycle between the STOP end and the next START.
REQ-027 busy SHALL be 1 whenever the FSM is not in IDLE.
REQ-028 irq_empty SHALL equal empty AND NOT busy.
REQ-029 A push and a pop in the same cycle SHALL both occur, including when count==4: count stays 4 and the byte is accepted with no overflow. The pointers are 2-bit and wrap modulo 4.
REQ-030 tx, empty, busy and irq_empty SHALL be registered or decoded only from registered state; no combinational path from the bus inputs to tx.
REQ-031 Latency: a DATA write at edge k SHALL, with the FIFO empty and the FSM idle, drive tx low starting after edge k+1.

Reset
REQ-032 On reset assertion, immediately and independent of clk: FSM=IDLE, tx=1, FIFO pointers and count=0, ovf=0, div=DIV_RESET, shift register=0, bit and clock counters=0.
REQ-033 Reset mid-frame SHALL abort the frame with no partial completion; tx returns high at once.
REQ-034 The reset values of the outputs SHALL be: received_data=0 (no read active), tx=1, irq_empty=1.

Verification
REQ-035 Reset, then read STATUS -> 32'h00000002; read DIV -> 32'h000001B2.
REQ-036 Write DIV=4, then DATA=0x55 -> tx low for 4 clocks starting one cycle after the write, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high for 4 clocks; busy high for 40 clocks; irq_empty returns to 1.
REQ-037 With DIV=4, write 6 bytes 0x01..0x06 on consecutive cycles -> bytes 0x01..0x05 are transmitted in order (the first is popped before the 6th write), 0x06 is dropped, and STATUS bit2=1; a second STATUS read returns bit2=0.
REQ-038 With the FIFO at count=4 and the FSM entering IDLE, write DATA=0xA5 in the pop cycle -> count stays 4, ovf stays 0, and 0xA5 is later transmitted last.
REQ-039 Assert reset during DATA bit 3 of a frame -> tx=1 in the same cycle, STATUS reads 32'h00000002 after release, and no further edges occur on tx.
REQ-040 Write DIV=0, then DATA=0xFF -> frame length 10 clocks; reads at an unmapped address such as BASE_ADDR+12 return 32'h0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter with 4-entry TX FIFO
//
// Ports:
//   clk            processor clock, all state on rising edge
//   reset          asynchronous active-high reset
//   memwrite       store strobe
//   memread        load strobe
//   data_address   byte address of the access
//   writedata      store data
//   received_data  load data, combinational from data_address/memread
//   tx             UART serial line, idle high
//   irq_empty      FIFO empty and transmitter idle
//
// Registers: DATA @BASE_ADDR (write pushes a byte), STATUS @+4
// ({count, ovf, empty, busy}, read clears ovf), DIV @+8 (clocks per bit).

module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h10010024,
    parameter logic [15:0] DIV_RESET  = 16'd434,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] data_address,
    input  logic [31:0] writedata,
    output logic [31:0] received_data,
    output logic        tx,
    output logic        irq_empty
);

    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [31:0] DIV_ADDR    = BASE_ADDR + 32'd8;
    localparam logic [2:0]  FULL_COUNT  = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      state;
    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        ovf;
    logic [15:0] div;
    logic [15:0] div_lat;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;

    logic sel_data, sel_status, sel_div;
    logic wr_data, wr_div, rd_status;
    logic push, pop, ovf_set;
    logic busy, empty, bit_end;

    logic unused_wdata;
    assign unused_wdata = ^writedata[31:16];

    assign sel_data   = (data_address == BASE_ADDR);
    assign sel_status = (data_address == STATUS_ADDR);
    assign sel_div    = (data_address == DIV_ADDR);

    assign wr_data   = memwrite & sel_data;
    assign wr_div    = memwrite & sel_div;
    assign rd_status = memread & sel_status;

    // The FSM drains the head whenever it sits in IDLE with data queued, so a
    // push into a full FIFO in that same cycle still finds room.
    assign pop     = (state == S_IDLE) && (count != 3'd0);
    assign push    = wr_data && ((count != FULL_COUNT) || pop);
    assign ovf_set = wr_data && (count == FULL_COUNT) && !pop;

    assign busy      = (state != S_IDLE);
    assign empty     = (count == 3'd0);
    assign irq_empty = empty & ~busy;
    assign bit_end   = (clk_cnt == div_lat - 16'd1);

    always_comb begin
        received_data = 32'h0;
        if (memread) begin
            if (sel_status)
                received_data = {26'b0, count, ovf, empty, busy};
            else if (sel_div)
                received_data = {16'b0, div};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= writedata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Set wins over the read-clear when both land in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf <= 1'b0;
        else if (ovf_set)
            ovf <= 1'b1;
        else if (rd_status)
            ovf <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div <= DIV_RESET;
        else if (wr_div)
            div <= writedata[15:0];
    end

    // div_lat holds the effective divider (0 promoted to 1) for the whole
    // frame so DIV writes mid-frame only affect the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            shift   <= 8'h00;
            div_lat <= 16'd1;
            clk_cnt <= 16'd0;
            bit_cnt <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= fifo_mem[rd_ptr];
                        div_lat <= (div == 16'd0) ? 16'd1 : div;
                        clk_cnt <= 16'd0;
                        bit_cnt <= 3'd0;
                        tx      <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt <= 16'd0;
                        tx      <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= 16'd0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= 16'd0;
                        state   <= S_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard testbench for uart_tx_mmio

module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h10010024;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_DIV  = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [31:0] data_address = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] received_data;
    logic        tx;
    logic        irq_empty;

    typedef struct packed {
        logic [7:0]  b;
        logic [15:0] n;
    } frame_t;

    frame_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    uart_tx_mmio dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
        .data_address(data_address), .writedata(writedata),
        .received_data(received_data), .tx(tx), .irq_empty(irq_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; data_address = a; writedata = d;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        memread = 1'b1; data_address = a;
        #1 d = received_data;
        @(negedge clk);
        memread = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (irq_empty !== 1'b1 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check("idle_timeout", 32'(c < 5000), 32'd1);
    endtask

    // Number of cycles irq_empty stays low after a write, starting at the
    // negedge right after the write edge; also records tx at offsets 0 and 1.
    task automatic measure_busy(output int cnt, output logic tx0, output logic tx1);
        cnt = 0; tx0 = tx; tx1 = 1'bx;
        while (irq_empty === 1'b0 && cnt < 5000) begin
            if (cnt == 1) tx1 = tx;
            @(negedge clk);
            cnt++;
        end
    endtask

    // Monitor: decodes frames off the tx line, sampling the first cycle of
    // each bit, and compares them to the scoreboard.
    initial begin
        frame_t e;
        logic [7:0] got;
        logic s0, s1;
        int n;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", 32'(sb.size()), 32'd1);
                    e = '0;
                    n = 1;
                end else begin
                    e = sb.pop_front();
                    n = int'(e.n);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (n) @(negedge clk);
                    got[i] = tx;
                end
                repeat (n) @(negedge clk);
                s0 = tx;
                repeat (n - 1) @(negedge clk);
                s1 = tx;
                check("frame_byte", {24'h0, got}, {24'h0, e.b});
                check("stop_bit", {30'h0, s0, s1}, 32'd3);
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        int cnt, d, eff, len, lows;
        logic t0, t1;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and register map
        check("rst_tx", {31'h0, tx}, 32'd1);
        check("rst_irq", {31'h0, irq_empty}, 32'd1);
        check("rst_rdata", received_data, 32'h0);
        rd(A_STAT, r); check("rst_status", r, 32'h00000002);
        rd(A_DIV, r);  check("rst_div", r, 32'h000001B2);
        rd(A_DATA, r); check("data_read", r, 32'h0);
        rd(BASE + 32'd12, r); check("unmapped_read", r, 32'h0);
        data_address = A_STAT; #1 check("no_memread", received_data, 32'h0);
        @(negedge clk);

        // Single 0x55 frame at DIV=4
        wr(A_DIV, 32'd4);
        rd(A_DIV, r); check("div4", r, 32'd4);
        sb.push_back('{8'h55, 16'd4});
        wr(A_DATA, 32'h55);
        measure_busy(cnt, t0, t1);
        check("latency_tx_k", {31'h0, t0}, 32'd1);
        check("latency_tx_k1", {31'h0, t1}, 32'd0);
        check("frame_len_div4", 32'(cnt), 32'd41);
        check("irq_back", {31'h0, irq_empty}, 32'd1);

        // Overflow burst of six bytes
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) sb.push_back('{8'(i), 16'd4});
            wr(A_DATA, 32'(i));
        end
        rd(A_STAT, r); check("burst_status", r, 32'h00000025);
        wait_idle();
        rd(A_STAT, r); check("ovf_clear", r, 32'h00000002);

        // Push into full FIFO in the pop cycle
        b = 8'($urandom);
        sb.push_back('{b, 16'd4});
        wr(A_DATA, {24'h0, b});
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            sb.push_back('{b, 16'd4});
            wr(A_DATA, {24'h0, b});
        end
        repeat (37) @(negedge clk);
        sb.push_back('{8'hA5, 16'd4});
        wr(A_DATA, 32'hA5);
        rd(A_STAT, r); check("full_pop_push", r, 32'h00000021);
        wait_idle();
        rd(A_STAT, r); check("full_pop_status", r, 32'h00000002);

        // DIV change mid-frame applies to the next frame only
        sb.push_back('{8'h3C, 16'd4});
        wr(A_DATA, 32'h3C);
        wr(A_DIV, 32'd2);
        sb.push_back('{8'hC3, 16'd2});
        wr(A_DATA, 32'hC3);
        wait_idle();
        rd(A_DIV, r); check("div2", r, 32'd2);

        // DIV=0 behaves as 1
        wr(A_DIV, 32'd0);
        rd(A_DIV, r); check("div0", r, 32'd0);
        sb.push_back('{8'hFF, 16'd1});
        wr(A_DATA, 32'hFF);
        measure_busy(cnt, t0, t1);
        check("frame_len_div0", 32'(cnt), 32'd11);
        rd(BASE + 32'd12, r); check("unmapped_read2", r, 32'h0);

        // Randomized bursts from idle: at most five bytes fit (one popped
        // immediately plus four queued), the rest overflow.
        for (int it = 0; it < 10; it++) begin
            d = $urandom_range(0, 6);
            eff = (d == 0) ? 1 : d;
            wr(A_DIV, 32'(d));
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                b = 8'($urandom);
                if (j < 5) sb.push_back('{b, 16'(eff)});
                wr(A_DATA, {24'h0, b});
            end
            wait_idle();
            rd(A_STAT, r); check("rand_status", r, (len > 5) ? 32'h6 : 32'h2);
            rd(A_STAT, r); check("rand_status2", r, 32'h2);
        end

        // Reset during data bit 3 aborts the frame; line reads high from
        // that point on, so upper bits decode as ones.
        wr(A_DIV, 32'd4);
        b = 8'($urandom);
        sb.push_back('{{4'hF, b[3:0]}, 16'd4});
        wr(A_DATA, {24'h0, b});
        repeat (18) @(negedge clk);
        reset = 1'b1;
        #1 check("reset_tx", {31'h0, tx}, 32'd1);
        check("reset_irq", {31'h0, irq_empty}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd(A_STAT, r); check("post_reset_status", r, 32'h00000002);
        rd(A_DIV, r);  check("post_reset_div", r, 32'h000001B2);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("no_tx_after_reset", 32'(lows), 32'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
